// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM-stage cpu port and the ext loader/debug port.
// Latency: accept in 0 cycles (the memory samples at the closing edge); read data is valid 1 cycle after the grant.
// Backpressure: cpu has priority and sees cpu_stall when ext wins; ext holds its request until ext_gnt.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        oob_err
);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       rsp_cpu;
    logic       rsp_ext;
    logic       rsp_oob;
    logic       ext_win;
    logic       cpu_win;
    logic       any_win;
    logic       in_range;
    req_t       sel;

    // The selected request is all-zero when nothing is granted, so the memory bus idles at 0.
    always_comb begin
        ext_win = ext_req && (!cpu_req || wait_cnt == WAIT_LIM);
        cpu_win = cpu_req && !ext_win;
        any_win = ext_win || cpu_win;
        sel     = '0;
        if (ext_win) begin
            sel = {ext_we, ext_addr, ext_wdata};
        end else if (cpu_win) begin
            sel = {cpu_we, cpu_addr, cpu_wdata};
        end
    end

    assign in_range  = (sel.addr[31:ADDR_W] == '0);
    assign ext_gnt   = ext_win;
    assign cpu_stall = cpu_req && ext_win;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;
    assign mem_we    = any_win && sel.we && in_range;
    assign mem_re    = any_win && !sel.we && in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            rsp_cpu  <= 1'b0;
            rsp_ext  <= 1'b0;
            rsp_oob  <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            if (ext_win || !ext_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            rsp_cpu <= cpu_win && !cpu_we;
            rsp_ext <= ext_win && !ext_we;
            rsp_oob <= any_win && !sel.we && !in_range;
            if (any_win && !in_range) begin
                oob_err <= 1'b1;
            end
        end
    end

    // Out-of-range reads still complete, but return zero instead of stale memory data.
    assign cpu_rvalid = rsp_cpu;
    assign cpu_rdata  = (rsp_cpu && !rsp_oob) ? mem_rdata : 32'd0;
    assign ext_rvalid = rsp_ext;
    assign ext_rdata  = (rsp_ext && !rsp_oob) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a word-level memory model.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, oob_err;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .oob_err(oob_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(int i);
        return {i[3:0], 20'h0, i[3:0], i[3:0]};
    endfunction

    // Data memory: loaded once at the first reset, read data registered.
    logic [31:0] mem [256];
    logic        loaded = 1'b0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
            if (!loaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                loaded <= 1'b1;
            end
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    // An ext request that was not granted must still be present the next cycle.
    logic ext_pend = 1'b0;
    always @(posedge clock) begin
        if (!reset && ext_pend && !ext_req) begin
            errors++;
            $display("FAIL ext_req_dropped: ext_req=%b while request pending, required 1", ext_req);
        end
        ext_pend <= ext_req && !ext_gnt;
    end

    // Reference model: memory contents, ext denial streak and the expected responses.
    logic [31:0] ref_mem [256];
    int          m_denied;
    logic        m_oob;
    logic        x_cv, x_ev;
    logic [31:0] x_cd, x_ed;

    task automatic model_reset();
        m_denied = 0; m_oob = 1'b0;
        x_cv = 1'b0; x_ev = 1'b0; x_cd = '0; x_ed = '0;
    endtask

    task automatic model_step();
        logic        eg, cg, we;
        logic [31:0] a, d, rd;
        eg = ext_req && (!cpu_req || m_denied == MAX_WAIT);
        cg = cpu_req && !eg;
        we = eg ? ext_we : cpu_we;
        a  = eg ? ext_addr : cpu_addr;
        d  = eg ? ext_wdata : cpu_wdata;
        rd = (a < 256) ? ref_mem[a] : 32'd0;
        x_cv = cg && !cpu_we;
        x_ev = eg && !ext_we;
        x_cd = x_cv ? rd : 32'd0;
        x_ed = x_ev ? rd : 32'd0;
        if ((eg || cg) && we && a < 256) ref_mem[a] = d;
        if ((eg || cg) && a >= 256) m_oob = 1'b1;
        if (ext_req && !eg) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
        else m_denied = 0;
    endtask

    task automatic adv();
        if (reset) model_reset(); else model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    endtask

    task automatic test_reset();
        idle();
        cpu_req = 1; cpu_addr = 32'd7;
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b/%b required 0/0", cpu_rvalid, ext_rvalid); end
        checks++; if (cpu_rdata !== 32'd0 || ext_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h/%h required 0/0", cpu_rdata, ext_rdata); end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL rst_oob: got %b required 0", oob_err); end
        checks++; if (mem_re !== 1'b1 || mem_addr !== 32'd7) begin errors++; $display("FAIL rst_comb_strobe: re=%b addr=%h required 1/7", mem_re, mem_addr); end
        adv();
        reset = 0; idle();
        adv();
    endtask

    task automatic test_cpu_read();
        idle(); cpu_req = 1; cpu_addr = 32'd5;
        @(negedge clock);
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd5) begin errors++; $display("FAIL cpu_rd_strobe: re=%b we=%b addr=%h required 1/0/5", mem_re, mem_we, mem_addr); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall: got %b required 0", cpu_stall); end
        adv(); idle();
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h50000055) begin errors++; $display("FAIL cpu_rd_data: rvalid=%b data=%h required 1/50000055", cpu_rvalid, cpu_rdata); end
        adv();
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_one_cycle: rvalid=%b required 0", cpu_rvalid); end
        adv();
    endtask

    task automatic test_ext_write_read();
        idle(); ext_req = 1; ext_we = 1; ext_addr = 32'd10; ext_wdata = 32'hDEADBEEF;
        @(negedge clock);
        checks++; if (ext_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ext_wr: gnt=%b we=%b wdata=%h required 1/1/deadbeef", ext_gnt, mem_we, mem_wdata); end
        adv(); ext_we = 0;
        @(negedge clock);
        checks++; if (ext_gnt !== 1'b1 || mem_re !== 1'b1 || cpu_stall !== 1'b0) begin errors++; $display("FAIL ext_rd_gnt: gnt=%b re=%b stall=%b required 1/1/0", ext_gnt, mem_re, cpu_stall); end
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_wr_no_rvalid: got %b required 0", ext_rvalid); end
        adv(); idle();
        @(negedge clock);
        checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEADBEEF || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL ext_rd_data: rvalid=%b data=%h cpu_rvalid=%b required 1/deadbeef/0", ext_rvalid, ext_rdata, cpu_rvalid); end
        adv();
    endtask

    task automatic test_starvation();
        logic want;
        idle(); ext_req = 1; ext_addr = 32'd2;
        for (int c = 1; c <= 12; c++) begin
            cpu_req = 1; cpu_addr = 32'($urandom_range(0, 31));
            want = (c == 5 || c == 10);
            @(negedge clock);
            checks++; if (ext_gnt !== want || cpu_stall !== want) begin errors++; $display("FAIL starve_c%0d: gnt=%b stall=%b required %b/%b", c, ext_gnt, cpu_stall, want, want); end
            if (c == 6 || c == 11) begin
                checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h20000022) begin errors++; $display("FAIL starve_rdata_c%0d: rvalid=%b data=%h required 1/20000022", c, ext_rvalid, ext_rdata); end
            end
            adv();
        end
        cpu_req = 0;
        @(negedge clock);
        checks++; if (ext_gnt !== 1'b1) begin errors++; $display("FAIL starve_drain: gnt=%b required 1", ext_gnt); end
        adv(); idle(); adv();
    endtask

    task automatic test_oob();
        idle(); cpu_req = 1; cpu_addr = 32'h100;
        @(negedge clock);
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL oob_strobe: re=%b we=%b stall=%b required 0/0/0", mem_re, mem_we, cpu_stall); end
        adv(); idle();
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd0) begin errors++; $display("FAIL oob_rdata: rvalid=%b data=%h required 1/0", cpu_rvalid, cpu_rdata); end
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b required 1", oob_err); end
        adv(); adv(); adv();
        @(negedge clock);
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b required 1", oob_err); end
        adv();
    endtask

    task automatic test_same_addr();
        idle();
        cpu_req = 1; cpu_addr = 32'd3;
        ext_req = 1; ext_we = 1; ext_addr = 32'd3; ext_wdata = 32'h33333333;
        @(negedge clock);
        checks++; if (ext_gnt !== 1'b0 || mem_re !== 1'b1 || mem_addr !== 32'd3) begin errors++; $display("FAIL same_c1: gnt=%b re=%b addr=%h required 0/1/3", ext_gnt, mem_re, mem_addr); end
        adv(); cpu_req = 0;
        @(negedge clock);
        checks++; if (ext_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL same_c2_gnt: gnt=%b we=%b required 1/1", ext_gnt, mem_we); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h30000033) begin errors++; $display("FAIL same_old: rvalid=%b data=%h required 1/30000033", cpu_rvalid, cpu_rdata); end
        adv(); idle(); cpu_req = 1; cpu_addr = 32'd3;
        @(negedge clock);
        adv(); idle();
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h33333333) begin errors++; $display("FAIL same_new: rvalid=%b data=%h required 1/33333333", cpu_rvalid, cpu_rdata); end
        adv();
    endtask

    task automatic test_reset_mid();
        idle(); cpu_req = 1; cpu_addr = 32'd7;
        @(negedge clock);
        adv(); idle(); reset = 1;
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin errors++; $display("FAIL midrst_drop: rvalid=%b data=%h required 0/0", cpu_rvalid, cpu_rdata); end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL midrst_oob: got %b required 0", oob_err); end
        adv(); reset = 0; cpu_req = 1; cpu_addr = 32'd5;
        @(negedge clock);
        adv(); idle();
        @(negedge clock);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h50000055) begin errors++; $display("FAIL midrst_read: rvalid=%b data=%h required 1/50000055", cpu_rvalid, cpu_rdata); end
        adv();
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h100 + 32'($urandom_range(0, 7));
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        logic        eg, cg, xwe, xre;
        logic [31:0] xa;
        idle();
        for (int n = 0; n < 400; n++) begin
            cpu_req = ($urandom_range(0, 3) != 0); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rnd_addr(); cpu_wdata = $urandom;
            if (!ext_req && $urandom_range(0, 2) == 0) begin
                ext_req = 1; ext_we = 1'($urandom_range(0, 1)); ext_addr = rnd_addr(); ext_wdata = $urandom;
            end
            @(negedge clock);
            eg  = ext_req && (!cpu_req || m_denied == MAX_WAIT);
            cg  = cpu_req && !eg;
            xa  = eg ? ext_addr : (cg ? cpu_addr : 32'd0);
            xwe = (eg && ext_we || cg && cpu_we) && xa < 256;
            xre = (eg && !ext_we || cg && !cpu_we) && xa < 256;
            checks++; if (ext_gnt !== eg || cpu_stall !== (cpu_req && eg)) begin errors++; $display("FAIL rnd_gnt n=%0d: gnt=%b stall=%b required %b/%b", n, ext_gnt, cpu_stall, eg, cpu_req && eg); end
            checks++; if (mem_addr !== xa || mem_we !== xwe || mem_re !== xre) begin errors++; $display("FAIL rnd_mem n=%0d: addr=%h we=%b re=%b required %h/%b/%b", n, mem_addr, mem_we, mem_re, xa, xwe, xre); end
            checks++; if (cpu_rvalid !== x_cv || cpu_rdata !== x_cd) begin errors++; $display("FAIL rnd_cpu_rsp n=%0d: rvalid=%b data=%h required %b/%h", n, cpu_rvalid, cpu_rdata, x_cv, x_cd); end
            checks++; if (ext_rvalid !== x_ev || ext_rdata !== x_ed) begin errors++; $display("FAIL rnd_ext_rsp n=%0d: rvalid=%b data=%h required %b/%h", n, ext_rvalid, ext_rdata, x_ev, x_ed); end
            checks++; if (oob_err !== m_oob) begin errors++; $display("FAIL rnd_oob n=%0d: got %b required %b", n, oob_err, m_oob); end
            adv();
            if (eg) ext_req = 0;
        end
        cpu_req = 0;
        adv(); idle(); adv();
    endtask

    initial begin
        reset = 1;
        idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_cpu_read();
        test_ext_write_read();
        test_starvation();
        test_oob();
        test_same_addr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
